// File: rtl/x9_pkg.sv
// Shared encodings for the X9 front end: instruction classes, control functs,
// ALU commands and the power-up contents of the branch-target LUT.
package x9_pkg;

    localparam logic [1:0] CLS_RTYPE = 2'b00;
    localparam logic [1:0] CLS_MEM   = 2'b01;
    localparam logic [1:0] CLS_MOVI  = 2'b10;
    localparam logic [1:0] CLS_CTRL  = 2'b11;

    localparam logic [2:0] FN_BEQ_ABS = 3'b000;
    localparam logic [2:0] FN_BEQ_REL = 3'b001;
    localparam logic [2:0] FN_JMP     = 3'b010;
    localparam logic [2:0] FN_HALT    = 3'b111;

    localparam logic [2:0] R_FUNCT_CMP = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SHL   = 4'd5,
        ALU_SHR   = 4'd6,
        ALU_CMP   = 4'd7,
        ALU_PASSA = 4'd8
    } alu_op_e;

    localparam int LUT_DEPTH = 16;

    // Entry k targets 8*k; the last entry is all ones so a relative branch through it steps back one.
    localparam logic [31:0] LUT_DEFAULT [LUT_DEPTH] = '{
        32'd0,   32'd8,   32'd16,  32'd24,
        32'd32,  32'd40,  32'd48,  32'd56,
        32'd64,  32'd72,  32'd80,  32'd88,
        32'd96,  32'd104, 32'd112, 32'hFFFF_FFFF
    };

endpackage

// File: rtl/fetch_ctrl_unit_branch_lut.sv
// Branch-target lookup table: maps the 4-bit index carried in control
// instructions to an absolute target or a signed PC offset.
module branch_lut
    import x9_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [3:0]   idx,
    output logic [D-1:0] target
);

    logic [31:0] entry;

    always_comb begin
        entry  = LUT_DEFAULT[idx];
        target = entry[D-1:0];
    end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// X9 front end: program counter with sticky halt, branch-target LUT and the
// combinational main decoder driving every datapath control.
module fetch_ctrl_unit
    import x9_pkg::*;
#(
    parameter int D = 12,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic         one_flag,
    output logic [D-1:0] prog_ctr,
    output logic [1:0]   InstType,
    output logic         BranchInst,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         ALUSrc,
    output logic         RegWrite,
    output logic         MemtoReg,
    output logic [A-1:0] ALUOp,
    output logic         done
);

    logic [1:0]   op_class;
    logic [2:0]   funct;
    logic         is_ctrl;
    logic         is_halt;
    logic         abs_taken;
    logic         rel_taken;
    logic [D-1:0] lut_target;
    logic [D-1:0] next_pc;
    alu_op_e      alu_cmd;

    assign op_class = mach_code[8:7];
    assign funct    = mach_code[6:4];

    branch_lut #(.D(D)) u_branch_lut (
        .idx    (mach_code[3:0]),
        .target (lut_target)
    );

    always_comb begin
        is_ctrl   = (op_class == CLS_CTRL);
        is_halt   = is_ctrl && (funct == FN_HALT);
        abs_taken = is_ctrl && ((funct == FN_JMP) || ((funct == FN_BEQ_ABS) && one_flag));
        rel_taken = is_ctrl && (funct == FN_BEQ_REL) && one_flag;
    end

    // Once halted (or while executing halt) the PC freezes; otherwise branch, else fall through.
    always_comb begin
        next_pc = prog_ctr + D'(1);
        if (done || is_halt) begin
            next_pc = prog_ctr;
        end else if (abs_taken) begin
            next_pc = lut_target;
        end else if (rel_taken) begin
            next_pc = prog_ctr + lut_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr <= '0;
            done     <= 1'b0;
        end else begin
            prog_ctr <= next_pc;
            if (is_halt) begin
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        InstType   = 2'b00;
        BranchInst = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        alu_cmd    = ALU_ADD;
        unique case (op_class)
            CLS_RTYPE: begin
                ALUSrc   = 1'b1;
                RegWrite = (funct != R_FUNCT_CMP);
                alu_cmd  = alu_op_e'({1'b0, funct});
            end
            CLS_MEM: begin
                InstType = 2'b10;
                ALUSrc   = 1'b1;
                alu_cmd  = ALU_PASSA;
                if (mach_code[0]) begin
                    MemWrite = 1'b1;
                end else begin
                    MemRead  = 1'b1;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
            end
            CLS_MOVI: begin
                InstType = 2'b11;
                RegWrite = 1'b1;
            end
            CLS_CTRL: begin
                BranchInst = (funct == FN_BEQ_ABS) || (funct == FN_BEQ_REL);
            end
            default: ;
        endcase
    end

    assign ALUOp = A'(alu_cmd);

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Self-checking bench for fetch_ctrl_unit: directed program walks followed by
// random instruction streams compared against an arithmetic reference model.
module tb_fetch_ctrl_unit;

    localparam int D = 12;
    localparam int A = 4;
    localparam int PC_MOD = 1 << D;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [8:0]   mach_code = 9'h180;
    logic         one_flag = 1'b0;
    logic [D-1:0] prog_ctr;
    logic [1:0]   InstType;
    logic         BranchInst;
    logic         MemRead;
    logic         MemWrite;
    logic         ALUSrc;
    logic         RegWrite;
    logic         MemtoReg;
    logic [A-1:0] ALUOp;
    logic         done;

    int errorCount = 0;
    int checkCount = 0;
    int modelPc = 0;
    bit modelDone = 1'b0;

    fetch_ctrl_unit #(.D(D), .A(A)) dut (
        .clk        (clk),
        .reset      (reset),
        .mach_code  (mach_code),
        .one_flag   (one_flag),
        .prog_ctr   (prog_ctr),
        .InstType   (InstType),
        .BranchInst (BranchInst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .ALUOp      (ALUOp),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int lutValue(input int k);
        return (k == 15) ? PC_MOD - 1 : 8 * k;
    endfunction

    // Expected control bundle {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, MemtoReg, ALUOp}.
    function automatic logic [11:0] refDecode(input logic [8:0] code);
        int cls = int'(code[8:7]);
        int fn  = int'(code[6:4]);
        int inst = 0, br = 0, mr = 0, mw = 0, src = 0, rw = 0, m2r = 0, op = 0;
        if (cls == 0) begin
            src = 1; op = fn; rw = (fn == 7) ? 0 : 1;
        end else if (cls == 1) begin
            inst = 2; src = 1; op = 8;
            if (code[0]) mw = 1;
            else begin mr = 1; m2r = 1; rw = 1; end
        end else if (cls == 2) begin
            inst = 3; rw = 1;
        end else begin
            br = (fn == 0 || fn == 1) ? 1 : 0;
        end
        return {2'(inst), 1'(br), 1'(mr), 1'(mw), 1'(src), 1'(rw), 1'(m2r), 4'(op)};
    endfunction

    // Called at a negedge; checks this cycle's outputs, then advances the model across the posedge.
    task automatic applyStimulus(input logic [8:0] code, input logic flag);
        int nextPc;
        bit nextDone;
        int cls, fn, idx;
        mach_code = code;
        one_flag  = flag;
        #1;
        checkOutput("prog_ctr", 32'(prog_ctr), 32'(modelPc));
        checkOutput("done", 32'(done), 32'(modelDone));
        checkOutput("decode", 32'({InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, MemtoReg, ALUOp}),
                    32'(refDecode(code)));
        cls = int'(code[8:7]);
        fn  = int'(code[6:4]);
        idx = int'(code[3:0]);
        nextPc = (modelPc + 1) % PC_MOD;
        nextDone = modelDone;
        if (modelDone) nextPc = modelPc;
        else if (cls == 3) begin
            if (fn == 7) begin nextPc = modelPc; nextDone = 1'b1; end
            else if (fn == 2 || (fn == 0 && flag)) nextPc = lutValue(idx);
            else if (fn == 1 && flag) nextPc = (modelPc + lutValue(idx)) % PC_MOD;
        end
        @(posedge clk);
        modelPc = nextPc;
        modelDone = nextDone;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        modelPc = 0;
        modelDone = 1'b0;
        checkOutput("reset_pc", 32'(prog_ctr), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic runNops(input int n);
        for (int i = 0; i < n; i++) applyStimulus(9'h180, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] rnd;
        @(negedge clk);
        @(negedge clk);
        doReset();
        runNops(3);
        applyStimulus(9'b00_001_0110, 1'b0);
        applyStimulus(9'b00_111_0010, 1'b1);
        applyStimulus(9'b11_000_0011, 1'b1);
        checkOutput("beq_abs_taken", 32'(prog_ctr), 32'd24);

        doReset();
        runNops(5);
        applyStimulus(9'b11_000_0011, 1'b0);
        checkOutput("beq_abs_not_taken", 32'(prog_ctr), 32'd6);
        applyStimulus(9'b01_010_0110, 1'b0);
        applyStimulus(9'b01_010_0111, 1'b0);
        applyStimulus(9'b10_101_1010, 1'b1);
        runNops(1);
        applyStimulus(9'b11_001_1111, 1'b1);
        checkOutput("beq_rel_back", 32'(prog_ctr), 32'd9);

        doReset();
        applyStimulus(9'b11_001_1111, 1'b1);
        checkOutput("beq_rel_wrap", 32'(prog_ctr), 32'd4095);
        runNops(1);
        checkOutput("pc_inc_wrap", 32'(prog_ctr), 32'd0);
        applyStimulus(9'b11_010_0010, 1'b0);
        checkOutput("jmp", 32'(prog_ctr), 32'd16);

        doReset();
        runNops(7);
        applyStimulus(9'b11_111_0000, 1'b0);
        checkOutput("halt_pc", 32'(prog_ctr), 32'd7);
        checkOutput("halt_done", 32'(done), 32'd1);
        applyStimulus(9'b11_010_0101, 1'b1);
        applyStimulus(9'h180, 1'b0);
        #2;
        doReset();

        for (int i = 0; i < 400; i++) begin
            rnd = 9'($urandom);
            if (rnd[8:7] == 2'b11 && rnd[6:4] == 3'b111 && ($urandom_range(0, 9) != 0)) rnd[6:4] = 3'b011;
            applyStimulus(rnd, 1'($urandom));
            if ($urandom_range(0, 59) == 0) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
